sha_msg_schedule: RTL and testbench

- Upstream producer for the SHA-256 compression round; it is the sending end of the round's `W_t`/`K_t` valid/ready input interface.
- Accepts one 512-bit message block as 16 serial 32-bit words.
- Emits `W_t` plus the matching `K_t` and round index for t = 0..63, one per output handshake.
- Window-based schedule: 16 x 32-bit shift window, 6-bit round counter, 64-entry constant ROM.

---
 rtl/sha_msg_schedule.sv | 134 +++++++++++++
 tb/tb_sha_msg_schedule.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_schedule.sv
// SHA-256 message schedule producer.
// Loads one 512-bit block as 16 serial big-endian words, then streams
// W_t / K_t / t for rounds 0..63 over a valid/ready handshake. The schedule
// is produced with a 16-word sliding window: w[0] is always the current W_t
// and each handshake appends the next expanded word at w[15].
module sha_msg_schedule (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] blk_word_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  output logic [31:0] W_t,
  output logic [31:0] K_t,
  output logic [5:0]  t_o,
  output logic        last_o,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic {ST_LOAD, ST_EMIT} state_t;

  localparam logic [31:0] K_ROM [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [5:0]  t_reg;
  logic        blk_ready_reg;
  logic        out_valid_reg;
  logic [31:0] w_reg [0:15];

  logic        accept;
  logic        fire;
  logic        shift_en;
  logic [31:0] w_new;
  logic [31:0] w_in;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign accept   = blk_valid_i & blk_ready_reg;
  assign fire     = out_valid_reg & out_ready;
  assign shift_en = accept | fire;

  // Next expanded word; the adds wrap at 32 bits by construction.
  assign w_new = sig1(w_reg[14]) + w_reg[9] + sig0(w_reg[1]) + w_reg[0];
  assign w_in  = (state_reg == ST_LOAD) ? blk_word_i : w_new;

  // Load/emit sequencing with registered handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_LOAD;
      cnt_reg       <= 4'd0;
      t_reg         <= 6'd0;
      blk_ready_reg <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (accept) begin
            cnt_reg <= cnt_reg + 4'd1;
            if (cnt_reg == 4'd15) begin
              state_reg     <= ST_EMIT;
              blk_ready_reg <= 1'b0;
              out_valid_reg <= 1'b1;
              t_reg         <= 6'd0;
            end else begin
              blk_ready_reg <= 1'b1;
            end
          end else begin
            blk_ready_reg <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (fire) begin
            if (t_reg == 6'd63) begin
              state_reg     <= ST_LOAD;
              t_reg         <= 6'd0;
              cnt_reg       <= 4'd0;
              out_valid_reg <= 1'b0;
              blk_ready_reg <= 1'b1;
            end else begin
              t_reg <= t_reg + 6'd1;
            end
          end
        end
        default: state_reg <= ST_LOAD;
      endcase
    end
  end

  // Sliding window: shift toward w[0], new word enters at w[15].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) w_reg[i] <= 32'd0;
    end else if (shift_en) begin
      for (int i = 0; i < 15; i++) w_reg[i] <= w_reg[i+1];
      w_reg[15] <= w_in;
    end
  end

  assign blk_ready_o = blk_ready_reg;
  assign out_valid   = out_valid_reg;
  assign W_t         = w_reg[0];
  assign K_t         = K_ROM[t_reg];
  assign t_o         = t_reg;
  assign last_o      = out_valid_reg & (t_reg == 6'd63);

endmodule

// File: tb/tb_sha_msg_schedule.sv
// Directed bench for sha_msg_schedule: reset values, "abc" and all-ones
// blocks, output backpressure, input gaps, rejected words, reset mid-emit.
module tb_sha_msg_schedule;

  logic        clk;
  logic        rst;
  logic [31:0] blk_word_i;
  logic        blk_valid_i;
  logic        blk_ready_o;
  logic [31:0] W_t;
  logic [31:0] K_t;
  logic [5:0]  t_o;
  logic        last_o;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  logic [31:0] blk   [0:15];
  logic [31:0] ref_w [0:63];

  sha_msg_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .blk_word_i (blk_word_i),
    .blk_valid_i(blk_valid_i),
    .blk_ready_o(blk_ready_o),
    .W_t        (W_t),
    .K_t        (K_t),
    .t_o        (t_o),
    .last_o     (last_o),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule in the textbook array form.
  task automatic build_ref();
    for (int i = 0; i < 16; i++) ref_w[i] = blk[i];
    for (int i = 16; i < 64; i++) begin
      ref_w[i] = (rr(ref_w[i-2], 17) ^ rr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10))
               + ref_w[i-7]
               + (rr(ref_w[i-15], 7) ^ rr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3))
               + ref_w[i-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic set_ones();
    for (int i = 0; i < 16; i++) blk[i] = 32'hffffffff;
    build_ref();
  endtask

  // Feed the 16 block words with an optional idle gap before each one.
  task automatic load_block(input int gap);
    logic rdy;
    int   wait_cnt;
    for (int i = 0; i < 16; i++) begin
      blk_valid_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      blk_valid_i = 1'b1;
      blk_word_i  = blk[i];
      wait_cnt = 0;
      do begin
        rdy = blk_ready_o;
        @(posedge clk); #1;
        wait_cnt++;
      end while (!rdy && wait_cnt < 50);
      check_val("load_accept", {31'd0, rdy}, 32'd1);
      $display("load word %0d = %h", i, blk[i]);
    end
    blk_valid_i = 1'b0;
    check_val("first_valid", {31'd0, out_valid}, 32'd1);
    check_val("first_t", {26'd0, t_o}, 32'd0);
  endtask

  // Consume the 64 outputs. kind: 1 = abc hand values, 2 = all-ones hand values.
  task automatic run_emit(input int stall_t, input int stop_t, input bit bogus, input int kind);
    int wait_cnt;
    out_ready = 1'b1;
    for (int t = 0; t < 64; t++) begin
      if (t == stop_t) return;
      wait_cnt = 0;
      while (!out_valid && wait_cnt < 20) begin @(posedge clk); #1; wait_cnt++; end
      check_val("out_valid", {31'd0, out_valid}, 32'd1);
      check_val("t_o", {26'd0, t_o}, t);
      check_val("W_t", W_t, ref_w[t]);
      check_val("last_o", {31'd0, last_o}, (t == 63) ? 32'd1 : 32'd0);
      if (t == 0)  check_val("K0", K_t, 32'h428a2f98);
      if (t == 1)  check_val("K1", K_t, 32'h71374491);
      if (t == 63) check_val("K63", K_t, 32'hc67178f2);
      if (kind == 1 && t == 0)  check_val("abc_W0", W_t, 32'h61626380);
      if (kind == 1 && t == 15) check_val("abc_W15", W_t, 32'h00000018);
      if (kind == 1 && t == 16) check_val("abc_W16", W_t, 32'h61626380);
      if (kind == 1 && t == 17) check_val("abc_W17", W_t, 32'h000f0000);
      if (kind == 2 && t == 0)  check_val("ones_W0", W_t, 32'hffffffff);
      if (kind == 2 && t == 16) check_val("ones_W16", W_t, 32'h203ffffc);
      $display("out t=%0d W=%h K=%h last=%0d", t_o, W_t, K_t, last_o);
      if (bogus && t >= 20 && t < 40) begin
        blk_valid_i = 1'b1;
        blk_word_i  = 32'hdeadbeef;
        check_val("ready_in_emit", {31'd0, blk_ready_o}, 32'd0);
      end else begin
        blk_valid_i = 1'b0;
      end
      if (t == stall_t) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk); #1;
          check_val("stall_valid", {31'd0, out_valid}, 32'd1);
          check_val("stall_t", {26'd0, t_o}, t);
          check_val("stall_W", W_t, 32'h61626380);
        end
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    blk_valid_i = 1'b0;
    check_val("done_ready", {31'd0, blk_ready_o}, 32'd1);
    check_val("done_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_ready"}, {31'd0, blk_ready_o}, 32'd0);
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_t"}, {26'd0, t_o}, 32'd0);
    check_val({tag, "_W"}, W_t, 32'd0);
    check_val({tag, "_K"}, K_t, 32'h428a2f98);
    check_val({tag, "_last"}, {31'd0, last_o}, 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    blk_word_i  = 32'd0;
    blk_valid_i = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst = 1'b0;
    #1;
    check_val("ready_pre_edge", {31'd0, blk_ready_o}, 32'd0);
    @(posedge clk); #1;
    check_val("ready_post_edge", {31'd0, blk_ready_o}, 32'd1);

    $display("block abc");
    set_abc();
    load_block(0);
    run_emit(-1, -1, 1'b0, 1);

    $display("block abc with backpressure at t=16");
    load_block(0);
    run_emit(16, -1, 1'b0, 1);

    $display("block abc with input gaps and rejected words");
    load_block(3);
    run_emit(-1, -1, 1'b1, 1);

    $display("back-to-back abc then all-ones");
    load_block(0);
    run_emit(-1, -1, 1'b0, 1);
    set_ones();
    load_block(0);
    run_emit(-1, -1, 1'b0, 2);

    $display("reset at t=30");
    set_abc();
    load_block(0);
    run_emit(-1, 30, 1'b0, 1);
    check_val("pre_rst_t", {26'd0, t_o}, 32'd30);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("midrst_ready_pre", {31'd0, blk_ready_o}, 32'd0);
    @(posedge clk); #1;
    check_val("midrst_ready_post", {31'd0, blk_ready_o}, 32'd1);
    load_block(0);
    run_emit(-1, -1, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
